// File: rtl/pwm_die_monitor.sv
// pwm_die_monitor: measures high and dead-time segments of a complementary PWM pair
// and flags overlap, out-of-order edges and lost pulses.
module pwm_die_monitor #(
  parameter int unsigned _RAM_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                  io_clk,
  input  logic                  rst_n,
  input  logic                  meas_en,
  input  logic                  err_clr,
  input  logic                  io_pulseIn_a,
  input  logic                  io_pulseIn_b,
  output logic [_RAM_WIDTH-1:0] high_a,
  output logic [_RAM_WIDTH-1:0] dead_ab,
  output logic [_RAM_WIDTH-1:0] high_b,
  output logic [_RAM_WIDTH-1:0] dead_ba,
  output logic [_RAM_WIDTH-1:0] period,
  output logic                  meas_valid,
  output logic                  overlap_err,
  output logic                  seq_err,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int unsigned W  = _RAM_WIDTH;
  localparam int unsigned SW = W + 3;
  localparam logic [W-1:0] TMO_LAST = W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, A_HIGH, DEAD_AB, B_HIGH, DEAD_BA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic a_s, b_s, a_d, b_d;
  logic a_rise, a_fall, b_rise, b_fall;
  logic [W-1:0] seg_cnt, seg_len;
  logic [W-1:0] r_ha, r_dab, r_hb, r_dba;
  logic [SW-1:0] seg_sum;
  logic tmo, pend;
  logic seg_clr, lat_ha, lat_dab, lat_hb, lat_dba, zero_ab, zero_ba, publish;
  logic set_ovl, set_seq, set_to;

  // Input synchronizers plus one delay stage for edge detection
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      a_d    <= 1'b0;
      b_d    <= 1'b0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], io_pulseIn_a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], io_pulseIn_b};
      a_d    <= a_s;
      b_d    <= b_s;
    end
  end

  assign a_s    = a_sync[SYNC_STAGES-1];
  assign b_s    = b_sync[SYNC_STAGES-1];
  assign a_rise = a_s & ~a_d;
  assign a_fall = ~a_s & a_d;
  assign b_rise = b_s & ~b_d;
  assign b_fall = ~b_s & b_d;
  assign tmo    = (seg_cnt == TMO_LAST);

  // Cycles spent in the segment that closes on this edge, saturating
  assign seg_len = (&seg_cnt) ? seg_cnt : seg_cnt + W'(1);
  assign seg_sum = SW'(r_ha) + SW'(r_dab) + SW'(r_hb) + SW'(r_dba);

  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Overlap beats any edge; edges beat a timeout on the same cycle
  always_comb begin
    state_nxt = state;
    seg_clr   = 1'b0;
    lat_ha    = 1'b0;
    lat_dab   = 1'b0;
    lat_hb    = 1'b0;
    lat_dba   = 1'b0;
    zero_ab   = 1'b0;
    zero_ba   = 1'b0;
    publish   = 1'b0;
    set_ovl   = 1'b0;
    set_seq   = 1'b0;
    set_to    = 1'b0;
    if (!meas_en) begin
      state_nxt = IDLE;
    end else if (a_s && b_s) begin
      set_ovl   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (a_rise) begin
            seg_clr   = 1'b1;
            state_nxt = A_HIGH;
          end
        end
        A_HIGH: begin
          if (a_fall) begin
            lat_ha  = 1'b1;
            seg_clr = 1'b1;
            if (b_rise) begin
              zero_ab   = 1'b1;
              state_nxt = B_HIGH;
            end else begin
              state_nxt = DEAD_AB;
            end
          end else if (tmo) begin
            set_to    = 1'b1;
            state_nxt = IDLE;
          end
        end
        DEAD_AB: begin
          if (a_rise) begin
            set_seq   = 1'b1;
            seg_clr   = 1'b1;
            state_nxt = A_HIGH;
          end else if (b_rise) begin
            lat_dab   = 1'b1;
            seg_clr   = 1'b1;
            state_nxt = B_HIGH;
          end else if (tmo) begin
            set_to    = 1'b1;
            state_nxt = IDLE;
          end
        end
        B_HIGH: begin
          if (b_fall) begin
            lat_hb  = 1'b1;
            seg_clr = 1'b1;
            if (a_rise) begin
              zero_ba   = 1'b1;
              publish   = 1'b1;
              state_nxt = A_HIGH;
            end else begin
              state_nxt = DEAD_BA;
            end
          end else if (tmo) begin
            set_to    = 1'b1;
            state_nxt = IDLE;
          end
        end
        DEAD_BA: begin
          if (b_rise) begin
            set_seq   = 1'b1;
            state_nxt = IDLE;
          end else if (a_rise) begin
            lat_dba   = 1'b1;
            seg_clr   = 1'b1;
            publish   = 1'b1;
            state_nxt = A_HIGH;
          end else if (tmo) begin
            set_to    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Segment counter and per-segment latches
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_cnt <= '0;
      r_ha    <= '0;
      r_dab   <= '0;
      r_hb    <= '0;
      r_dba   <= '0;
      pend    <= 1'b0;
    end else begin
      if (seg_clr)        seg_cnt <= '0;
      else if (!(&seg_cnt)) seg_cnt <= seg_cnt + W'(1);
      if (lat_ha)  r_ha  <= seg_len;
      if (zero_ab) r_dab <= '0;
      else if (lat_dab) r_dab <= seg_len;
      if (lat_hb)  r_hb  <= seg_len;
      if (zero_ba) r_dba <= '0;
      else if (lat_dba) r_dba <= seg_len;
      pend <= publish;
    end
  end

  // Published results, strobe, sticky flags and busy
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      high_a      <= '0;
      dead_ab     <= '0;
      high_b      <= '0;
      dead_ba     <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      overlap_err <= 1'b0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (pend && meas_en) begin
        high_a     <= r_ha;
        dead_ab    <= r_dab;
        high_b     <= r_hb;
        dead_ba    <= r_dba;
        period     <= (|seg_sum[SW-1:W]) ? '1 : seg_sum[W-1:0];
        meas_valid <= 1'b1;
      end
      overlap_err <= set_ovl | (overlap_err & ~err_clr);
      seq_err     <= set_seq | (seq_err & ~err_clr);
      timeout_err <= set_to  | (timeout_err & ~err_clr);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_die_monitor.sv
// Bench for pwm_die_monitor: drives PWM pin patterns and scoreboards every meas_valid strobe.
module tb_pwm_die_monitor;

  localparam int unsigned W    = 32;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned SYNC = 2;

  logic         io_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         meas_en = 1'b0;
  logic         err_clr = 1'b0;
  logic         pin_a = 1'b0;
  logic         pin_b = 1'b0;
  logic [W-1:0] high_a, dead_ab, high_b, dead_ba, period;
  logic         meas_valid, overlap_err, seq_err, timeout_err, busy;

  pwm_die_monitor #(
    ._RAM_WIDTH    (W),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .io_clk      (io_clk),
    .rst_n       (rst_n),
    .meas_en     (meas_en),
    .err_clr     (err_clr),
    .io_pulseIn_a(pin_a),
    .io_pulseIn_b(pin_b),
    .high_a      (high_a),
    .dead_ab     (dead_ab),
    .high_b      (high_b),
    .dead_ba     (dead_ba),
    .period      (period),
    .meas_valid  (meas_valid),
    .overlap_err (overlap_err),
    .seq_err     (seq_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 io_clk = ~io_clk;

  int cyc = 0;
  always @(posedge io_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned ha, dab, hb, dba, per;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests_run = 0;
  int tests_failed = 0;

  logic        armed = 1'b0;
  int unsigned c_ha, c_dab, c_hb, c_dba;

  // Scoreboard: every strobe must match the oldest expected cycle, values and arrival time
  always @(negedge io_clk) begin
    if (rst_n && meas_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL strobe: unexpected meas_valid at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        if ({high_a, dead_ab, high_b, dead_ba, period} !==
            {mon_e.ha, mon_e.dab, mon_e.hb, mon_e.dba, mon_e.per}) begin
          tests_failed++;
          $display("FAIL values: got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                   high_a, dead_ab, high_b, dead_ba, period,
                   mon_e.ha, mon_e.dab, mon_e.hb, mon_e.dba, mon_e.per);
        end
        tests_run++;
        if (cyc !== mon_e.cyc) begin
          tests_failed++;
          $display("FAIL latency: strobe at cycle %0d expected %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  // A rise on pin A; closes the previous full cycle if one is armed
  task automatic rise_a();
    exp_t e;
    if (armed) begin
      e.ha  = c_ha;
      e.dab = c_dab;
      e.hb  = c_hb;
      e.dba = c_dba;
      e.per = c_ha + c_dab + c_hb + c_dba;
      e.cyc = cyc + SYNC + 2;
      sb.push_back(e);
    end
    armed = 1'b0;
    pin_a = 1'b1;
  endtask

  task automatic run_cycle(input int unsigned ha, input int unsigned dab,
                           input int unsigned hb, input int unsigned dba);
    rise_a();
    wait_cyc(ha);
    pin_a = 1'b0;
    if (dab != 0) wait_cyc(dab);
    pin_b = 1'b1;
    wait_cyc(hb);
    pin_b = 1'b0;
    wait_cyc(dba);
    c_ha = ha; c_dab = dab; c_hb = hb; c_dba = dba;
    armed = 1'b1;
  endtask

  task automatic quiesce();
    pin_a = 1'b0;
    pin_b = 1'b0;
    meas_en = 1'b0;
    armed = 1'b0;
    wait_cyc(5);
    meas_en = 1'b1;
    wait_cyc(2);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    meas_en = 1'b1;
    repeat (3) @(negedge io_clk);
    tests_run++;
    if ({high_a, dead_ab, high_b, dead_ba, period} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %0d/%0d/%0d/%0d/%0d expected all 0",
               high_a, dead_ab, high_b, dead_ba, period);
    end
    tests_run++;
    if ({meas_valid, overlap_err, seq_err, timeout_err, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {meas_valid, overlap_err, seq_err, timeout_err, busy});
    end
    @(posedge io_clk); #1;
    rst_n = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_periodic();
    for (int i = 0; i < 4; i++) run_cycle(50, 5, 40, 5);
    rise_a();
    @(negedge io_clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL periodic_busy: got %b expected 1", busy);
    end
    wait_cyc(6);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL periodic_drain: %0d strobes missing, expected 0", sb.size());
    end
  endtask

  task automatic test_zero_dead();
    quiesce();
    run_cycle(60, 0, 30, 3);
    rise_a();
    wait_cyc(6);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_dead_drain: %0d strobes missing, expected 0", sb.size());
    end
    tests_run++;
    if ({overlap_err, seq_err, timeout_err} !== 3'b0) begin
      tests_failed++;
      $display("FAIL zero_dead_errs: got %b expected 000", {overlap_err, seq_err, timeout_err});
    end
  endtask

  task automatic test_meas_en();
    quiesce();
    @(negedge io_clk);
    tests_run++;
    if ({busy, overlap_err, seq_err, timeout_err} !== 4'b0) begin
      tests_failed++;
      $display("FAIL meas_en_flags: got %b expected 0000", {busy, overlap_err, seq_err, timeout_err});
    end
    tests_run++;
    if ({high_a, dead_ab, high_b, dead_ba, period} !== {32'd60, 32'd0, 32'd30, 32'd3, 32'd93}) begin
      tests_failed++;
      $display("FAIL meas_en_hold: got %0d/%0d/%0d/%0d/%0d expected 60/0/30/3/93",
               high_a, dead_ab, high_b, dead_ba, period);
    end
  endtask

  task automatic test_overlap();
    quiesce();
    rise_a();
    wait_cyc(20);
    pin_b = 1'b1;
    wait_cyc(2);
    pin_a = 1'b0;
    @(negedge io_clk);
    tests_run++;
    if ({overlap_err, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL overlap_before: got err=%b busy=%b expected err=0 busy=1", overlap_err, busy);
    end
    wait_cyc(1);
    @(negedge io_clk);
    tests_run++;
    if ({overlap_err, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL overlap_set: got err=%b busy=%b expected err=1 busy=0", overlap_err, busy);
    end
    pin_b = 1'b0;
    wait_cyc(5);
    pulse_clr();
    @(negedge io_clk);
    tests_run++;
    if (overlap_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL overlap_clr: got %b expected 0", overlap_err);
    end
    run_cycle(25, 4, 20, 6);
    rise_a();
    wait_cyc(6);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL overlap_drain: %0d strobes missing, expected 0", sb.size());
    end
  endtask

  task automatic test_seq();
    quiesce();
    rise_a();
    wait_cyc(20);
    pin_a = 1'b0;
    wait_cyc(10);
    run_cycle(30, 5, 25, 7);
    tests_run++;
    if (seq_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL seq_set: got %b expected 1", seq_err);
    end
    rise_a();
    wait_cyc(6);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL seq_drain: %0d strobes missing, expected 0", sb.size());
    end
  endtask

  task automatic test_timeout();
    quiesce();
    pulse_clr();
    @(negedge io_clk);
    tests_run++;
    if ({overlap_err, seq_err, timeout_err} !== 3'b0) begin
      tests_failed++;
      $display("FAIL timeout_pre: got %b expected 000", {overlap_err, seq_err, timeout_err});
    end
    wait_cyc(1);
    rise_a();
    wait_cyc(TMO + SYNC);
    err_clr = 1'b1;
    @(negedge io_clk);
    tests_run++;
    if ({timeout_err, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL timeout_early: got err=%b busy=%b expected err=0 busy=1", timeout_err, busy);
    end
    wait_cyc(1);
    err_clr = 1'b0;
    @(negedge io_clk);
    tests_run++;
    if ({timeout_err, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL timeout_set: got err=%b busy=%b expected err=1 busy=0", timeout_err, busy);
    end
    wait_cyc(5);
    pin_a = 1'b0;
    pulse_clr();
    @(negedge io_clk);
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clr: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    quiesce();
    rise_a();
    wait_cyc(20);
    pin_a = 1'b0;
    wait_cyc(5);
    pin_b = 1'b1;
    wait_cyc(10);
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({high_a, dead_ab, high_b, dead_ba, period, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got %0d/%0d/%0d/%0d/%0d busy=%b expected all 0",
               high_a, dead_ab, high_b, dead_ba, period, busy);
    end
    pin_b = 1'b0;
    armed = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    run_cycle(35, 2, 30, 3);
    rise_a();
    wait_cyc(6);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_drain: %0d strobes missing, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_zero_dead();
    test_meas_en();
    test_overlap();
    test_seq();
    test_timeout();
    test_reset_mid();
    quiesce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pwm_die_monitor.md
Name: pwm_die_monitor

Overview:
- Receive-side counterpart of half_pwm_die: captures a complementary dead-time PWM pair, io_pulseIn_a and io_pulseIn_b.
- Measures, per cycle in io_clk ticks: A high time, A-fall→B-rise dead time, B high time, B-fall→A-rise dead time, and total period.
- Flags shoot-through (overlap), sequence violations and loss of pulses.
- Used on loop-back pins for self-test and by bench/firmware to check die_period and pulse_period settings.

Parameters:
- _RAM_WIDTH, 32, width of every measurement output and internal segment counter.
- TIMEOUT_CYCLES, 1000000, maximum cycles in any non-IDLE state before timeout_err.
- SYNC_STAGES, 2, synchronizer flops per input (minimum 2).

Ports:
- io_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- meas_en  in  1  1 = measure; 0 = FSM forced to IDLE, outputs held.
- err_clr  in  1  one-cycle pulse; clears all sticky error flags.
- io_pulseIn_a  in  1  asynchronous PWM leg A.
- io_pulseIn_b  in  1  asynchronous PWM leg B.
- high_a  out  _RAM_WIDTH  cycles A was high.
- dead_ab  out  _RAM_WIDTH  cycles between A low and B high.
- high_b  out  _RAM_WIDTH  cycles B was high.
- dead_ba  out  _RAM_WIDTH  cycles between B low and next A high.
- period  out  _RAM_WIDTH  saturating sum of the four segments.
- meas_valid  out  1  one-cycle strobe; new values on outputs.
- overlap_err  out  1  sticky; A and B both high.
- seq_err  out  1  sticky; edge out of order.
- timeout_err  out  1  sticky; no edge within TIMEOUT_CYCLES.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizers and edge registers 0.
- Inputs pass through SYNC_STAGES flops to a_s and b_s, plus one delay flop for edge detect.
- Pin-to-edge-event latency is SYNC_STAGES+1 cycles. All measurements refer to a_s and b_s.
- Segment length = number of io_clk cycles the sampled pair stayed in that segment. A zero-length dead time (A falls and B rises on the same cycle) is legal and reports 0.
- seg_cnt clears on every accepted edge and increments each cycle. It saturates at all-ones and does not wrap.
- FSM states: IDLE, A_HIGH, DEAD_AB, B_HIGH, DEAD_BA.
- IDLE → A_HIGH on A rise with b_s=0 and meas_en=1.
- A_HIGH → DEAD_AB on A fall; latch high_a.
- DEAD_AB → B_HIGH on B rise; latch dead_ab.
- B_HIGH → DEAD_BA on B fall; latch high_b.
- DEAD_BA → A_HIGH on A rise; latch dead_ba.
- On that final A rise, the next cycle: update all five outputs together, compute period (saturating at 2^_RAM_WIDTH-1), and pulse meas_valid for 1 cycle.
- The first cycle after leaving IDLE never produces meas_valid until the full sequence completes.
- Overlap: a_s=1 and b_s=1 in any cycle sets overlap_err and sends the FSM to IDLE (partial measurement discarded). Overlap has priority over any simultaneous edge.
- Sequence error: A rise in DEAD_AB, or B rise in DEAD_BA, sets seq_err. A rise restarts at A_HIGH with seg_cnt=0. B rise goes to IDLE.
- Timeout: seg_cnt reaching TIMEOUT_CYCLES-1 in a non-IDLE state sets timeout_err and sends the FSM to IDLE.
- meas_en falling mid-cycle: FSM goes to IDLE next cycle, no meas_valid, no error set. Outputs keep their last published values.
- err_clr and an error condition on the same cycle: the error wins (flag stays 1).
- Outputs change only on a meas_valid cycle or reset.
- busy = (state != IDLE), registered.

Test Plan:
- Periodic pattern: A high 50 cycles, dead 5, B high 40, dead 5, repeated 4 times → from the 2nd A rise, meas_valid every 100 cycles. Values: high_a=50, dead_ab=5, high_b=40, dead_ba=5, period=100. First strobe arrives SYNC_STAGES+2 cycles after that pin edge.
- Zero dead time: A falls and B rises on the same io_clk edge, B high 30, dead 3 → dead_ab=0, period=high_a+30+3. No errors.
- Shoot-through: B rises 2 cycles before A falls → overlap_err=1, busy=0 next cycle, no meas_valid. err_clr then clears overlap_err. A clean cycle then produces valid outputs.
- Sequence error: A high 20, low 10, A high again with no B pulse → seq_err=1, measurement restarts. The following clean cycle gives correct values.
- Timeout with TIMEOUT_CYCLES=1000: A held high indefinitely → timeout_err=1 exactly 1000 cycles after the A-rise event, FSM in IDLE. A error on the same cycle as err_clr leaves the flag set.
- Reset mid-measurement: rst_n low during B_HIGH → all outputs 0 immediately (asynchronous). After release, the first meas_valid comes only after a full new A→A cycle.
